// File: rtl/halt_dump_ctrl.sv
// halt_dump_ctrl: CPU-side end of the halt/register-dump protocol.
// Spots the halt ECALL (ECALL with x17 == HALT_CODE), freezes the datapath,
// streams every register file entry over a valid/ready port, then raises a
// sticky is_halted. Also keeps a saturating cycle count for the final report.
//
// Build option: define HALT_DUMP_SKIP_X0_EN to start the dump at x1 instead
// of x0 (NUM_REGS-1 beats instead of NUM_REGS).
module halt_dump_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int XLEN      = 32,
  parameter int IDX_W     = 5,
  parameter int HALT_CODE = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic             is_ecall,
  input  logic [XLEN-1:0]  x17_val,
  output logic             cpu_stall,
  output logic [IDX_W-1:0] rf_rd_idx,
  input  logic [XLEN-1:0]  rf_rd_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]  dump_data,
  output logic [31:0]      total_cycle,
  output logic             is_halted
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DUMP,
    ST_HALTED
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
`ifdef HALT_DUMP_SKIP_X0_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(0);
`endif

  state_t           state_q, state_d;
  logic [IDX_W-1:0] dump_idx_q, dump_idx_d;
  logic [31:0]      total_cycle_q, total_cycle_d;
  logic             is_halted_q, is_halted_d;
  logic             dump_valid_q, dump_valid_d;
  logic             halt_hit;

  // Halt request is only recognised while running; the stall must be
  // combinational so the ECALL itself never advances the PC.
  always_comb begin
    halt_hit  = (state_q == ST_RUN) && instr_valid && is_ecall &&
                (x17_val == XLEN'(HALT_CODE));
    cpu_stall = halt_hit || (state_q != ST_RUN);
  end

  // Next-state logic: RUN -> DRAIN -> DUMP -> HALTED, plus the cycle counter.
  always_comb begin
    state_d       = state_q;
    dump_idx_d    = dump_idx_q;
    total_cycle_d = total_cycle_q;
    if ((state_q != ST_HALTED) && (total_cycle_q != 32'hFFFF_FFFF)) begin
      total_cycle_d = total_cycle_q + 32'd1;
    end
    case (state_q)
      ST_RUN: begin
        if (halt_hit) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DUMP;
      end
      ST_DUMP: begin
        if (dump_ready) begin
          if (dump_idx_q == LAST_IDX) begin
            state_d = ST_HALTED;
          end else begin
            dump_idx_d = dump_idx_q + IDX_W'(1);
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    dump_valid_d = (state_d == ST_DUMP);
    is_halted_d  = (state_d == ST_HALTED);
  end

  // State and registered outputs; reset may arrive at any point, even mid-dump.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      dump_idx_q    <= FIRST_IDX;
      total_cycle_q <= 32'd0;
      is_halted_q   <= 1'b0;
      dump_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      dump_idx_q    <= dump_idx_d;
      total_cycle_q <= total_cycle_d;
      is_halted_q   <= is_halted_d;
      dump_valid_q  <= dump_valid_d;
    end
  end

  // The register file is frozen during the dump, so a combinational read
  // keeps dump_data stable while a beat waits for ready.
  always_comb begin
    rf_rd_idx   = dump_idx_q;
    dump_idx    = dump_idx_q;
    dump_data   = rf_rd_data;
    dump_valid  = dump_valid_q;
    total_cycle = total_cycle_q;
    is_halted   = is_halted_q;
  end

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// tb_halt_dump_ctrl: randomized scoreboard bench for halt_dump_ctrl.
// A behavioural register file drives rf_rd_data; a model snapshots the
// expected beats into a queue at the halt, and a negedge monitor compares.
module tb_halt_dump_ctrl;

  localparam int NREGS = 32;
`ifdef HALT_DUMP_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        is_ecall;
  logic [31:0] x17_val;
  logic        cpu_stall;
  logic [4:0]  rf_rd_idx;
  logic [31:0] rf_rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic [31:0] total_cycle;
  logic        is_halted;

  logic [31:0] rf [NREGS];

  int checks = 0;
  int errors = 0;

  beat_t exp_q[$];
  bit    m_hit_seen;
  int    m_wait;
  bit    m_halted;
  int    m_total;
  int    hold4;

  halt_dump_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .is_ecall    (is_ecall),
    .x17_val     (x17_val),
    .cpu_stall   (cpu_stall),
    .rf_rd_idx   (rf_rd_idx),
    .rf_rd_data  (rf_rd_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_idx    (dump_idx),
    .dump_data   (dump_data),
    .total_cycle (total_cycle),
    .is_halted   (is_halted)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural register file with combinational read.
  always_comb begin
    rf_rd_data = rf[rf_rd_idx];
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input bit iv, input bit ie, input logic [31:0] x17,
                               input bit rdy);
    @(posedge clk);
    #1;
    instr_valid = iv;
    is_ecall    = ie;
    x17_val     = x17;
    dump_ready  = rdy;
  endtask

  task automatic doReset(input int cycles);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    instr_valid = 1'b0;
    is_ecall    = 1'b0;
    dump_ready  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic loadRf(input bit random_fill);
    for (int i = 0; i < NREGS; i++) begin
      rf[i] = random_fill ? $urandom : (i * 4 + 1);
    end
  endtask

  function automatic logic [31:0] nonHaltCode();
    logic [31:0] r;
    r = $urandom_range(0, 40);
    return (r == 32'd10) ? 32'd11 : r;
  endfunction

  // Random instruction traffic that can never be a halt.
  task automatic idleCycle(input bit rdy);
    int kind;
    kind = $urandom_range(0, 3);
    case (kind)
      0: applyStimulus(1'b1, 1'b1, 32'd9, rdy);
      1: applyStimulus(1'b0, 1'b1, 32'd10, rdy);
      2: applyStimulus(1'b1, 1'b0, 32'd10, rdy);
      default: applyStimulus(1'b1, 1'b1, nonHaltCode(), rdy);
    endcase
  endtask

  // Drive until halted. mode 0: ready=1; mode 1: random ready with a forced
  // 3-cycle hold at index 4; mode 2: reset once index 10 is presented.
  task automatic runDump(input int mode);
    bit rdy;
    bit done;
    done  = 1'b0;
    hold4 = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (is_halted) begin
        done = 1'b1;
      end else if (mode == 2 && dump_valid && dump_idx == 5'd10) begin
        doReset(1);
        return;
      end else begin
        if (mode == 0) begin
          rdy = 1'b1;
        end else if (mode == 1 && dump_valid && dump_idx == 5'd4 && hold4 < 3) begin
          rdy = 1'b0;
          hold4++;
        end else begin
          rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      ($urandom_range(0, 1) == 1) ? 32'd10 : nonHaltCode(), rdy);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL halt_timeout: got is_halted=%0b expected 1", is_halted);
    end
    repeat (4) applyStimulus(1'b1, 1'b1, 32'd10, 1'b1);
  endtask

  // Monitor: compare DUT against the model, then advance the model one cycle.
  always @(negedge clk) begin
    bit    hit;
    bit    exp_valid;
    beat_t b;
    if (reset) begin
      exp_q.delete();
      m_hit_seen = 1'b0;
      m_wait     = 0;
      m_halted   = 1'b0;
      m_total    = 0;
    end else begin
      hit       = !m_hit_seen && instr_valid && is_ecall && (x17_val == 32'd10);
      exp_valid = m_hit_seen && (m_wait == 0) && !m_halted;
      checkOutput("cpu_stall", {31'd0, cpu_stall}, {31'd0, (m_hit_seen || hit)});
      checkOutput("dump_valid", {31'd0, dump_valid}, {31'd0, exp_valid});
      checkOutput("is_halted", {31'd0, is_halted}, {31'd0, m_halted});
      checkOutput("total_cycle", total_cycle, m_total);
      if (dump_valid && exp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got idx %0d expected no beat", dump_idx);
        end else begin
          b = exp_q[0];
          checkOutput("dump_idx", {27'd0, dump_idx}, {27'd0, b.idx});
          checkOutput("rf_rd_idx", {27'd0, rf_rd_idx}, {27'd0, b.idx});
          checkOutput("dump_data", dump_data, b.data);
          if (dump_ready) begin
            void'(exp_q.pop_front());
          end
        end
      end
      if (!m_halted) begin
        m_total++;
      end
      if (hit) begin
        m_hit_seen = 1'b1;
        m_wait     = 1;
        for (int i = FIRST; i < NREGS; i++) begin
          exp_q.push_back('{idx: 5'(i), data: rf[i]});
        end
      end else if (m_hit_seen && m_wait > 0) begin
        m_wait--;
      end else if (exp_valid && dump_ready && exp_q.size() == 0) begin
        m_halted = 1'b1;
      end
    end
  end

  // Scenario sequence.
  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    is_ecall    = 1'b0;
    x17_val     = 32'd0;
    dump_ready  = 1'b0;

    $display("[TB] full dump, ready held high, rf[i] = i*4+1");
    loadRf(1'b0);
    doReset(2);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'd10, 1'b1);
    runDump(0);

    $display("[TB] non-halt ECALLs and bubbles, then backpressured dump");
    loadRf(1'b1);
    doReset(2);
    repeat (20) idleCycle($urandom_range(0, 1) == 1);
    applyStimulus(1'b1, 1'b1, 32'd10, 1'b0);
    runDump(1);

    $display("[TB] reset in mid-dump, then fresh dump");
    loadRf(1'b1);
    doReset(2);
    repeat (3) idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 32'd10, 1'b1);
    runDump(2);
    repeat (3) idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 32'd10, 1'b1);
    runDump(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
